psimd_instr_queue: RTL

- Fetch-side instruction queue directly downstream of the PSIMD instruction buffer.
- Accepts one 32-bit instruction per cycle and holds it in a DEPTH-entry FIFO.
- Pre-decodes the head entry into PSIMD fields and an operation class, then issues it to the decode/execute stage over a valid/ready handshake.
- Tracks illegal opcodes and dropped (overflow) pushes for debug.

---
 rtl/psimd_instr_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/psimd_instr_queue.sv
// PSIMD instruction queue: DEPTH-entry FIFO that pre-decodes its head entry into
// PSIMD fields and an operation class, with illegal-opcode and overflow tracking.
module psimd_instr_queue #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [31:0]                in_instr,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [6:0]                 out_opcode,
   output logic [4:0]                 out_rd,
   output logic [2:0]                 out_funct3,
   output logic [4:0]                 out_rs1,
   output logic [4:0]                 out_rs2,
   output logic [1:0]                 out_fmt,
   output logic [4:0]                 out_funct5,
   output logic [1:0]                 out_opcls,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow_err,
   output logic [CNT_W-1:0]           illegal_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [6:0] OP_VALU  = 7'b1011011;
   localparam logic [6:0] OP_LOAD  = 7'b0011011;
   localparam logic [6:0] OP_STORE = 7'b0111011;

   function automatic logic [1:0] op_class(input logic [6:0] op);
      case (op)
         OP_VALU:  op_class = 2'd0;
         OP_LOAD:  op_class = 2'd1;
         OP_STORE: op_class = 2'd2;
         default:  op_class = 2'd3;
      endcase
   endfunction

   logic [31:0]      mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

   logic        accept;
   logic        enq;
   logic        deq;
   logic [31:0] head;

   // Handshake: a transfer happens on a cycle where valid && ready are both high at
   // the rising edge; in_ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign accept    = in_valid && in_ready && !flush;
   assign enq       = accept && (in_instr != 32'h0);
   assign deq       = out_valid && out_ready && !flush;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      illegal_cnt_d = illegal_cnt_q;
      if (in_valid && !in_ready && (in_instr != 32'h0) && !flush) begin
         overflow_d = 1'b1;
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         // Bubbles are never enqueued, so they never count as illegal.
         if (enq && (op_class(in_instr[6:0]) == 2'd3) && (illegal_cnt_q != '1)) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         illegal_cnt_q <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (rst_n && enq) begin
         mem_q[wr_ptr_q] <= in_instr;
      end
   end

   assign head         = out_valid ? mem_q[rd_ptr_q] : 32'h0;
   assign out_instr    = head;
   assign out_opcode   = head[6:0];
   assign out_rd       = head[11:7];
   assign out_funct3   = head[14:12];
   assign out_rs1      = head[19:15];
   assign out_rs2      = head[24:20];
   assign out_fmt      = head[26:25];
   assign out_funct5   = head[31:27];
   assign out_opcls    = out_valid ? op_class(head[6:0]) : 2'd0;
   assign count        = count_q;
   assign overflow_err = overflow_q;
   assign illegal_cnt  = illegal_cnt_q;

endmodule
